// File: rtl/clock_controller_pkg.sv
// Shared types for the run/halt/step clock sequencer.
package clock_controller_pkg;

  localparam int unsigned DATAWIDTH = 16;

  // Sequencer state; drain is RUN with a pending halt, not a separate state.
  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } state_e;

  // Reason for the most recent stop, visible to the debug card.
  typedef enum logic [1:0] {
    HC_RESET = 2'd0,
    HC_USER  = 2'd1,
    HC_BREAK = 2'd2,
    HC_STEP  = 2'd3
  } halt_cause_e;

endpackage

// File: rtl/clock_phase_gen.sv
// Instruction phase counter: clear/advance, one-hot decode and last-phase flag.
module clock_phase_gen #(
  parameter int unsigned NPHASE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [NPHASE-1:0] onehot,
  output logic              last
);

  localparam int unsigned PW = (NPHASE > 1) ? $clog2(NPHASE) : 1;

  logic [PW-1:0] phase_q;

  assign last = (phase_q == PW'(NPHASE - 1));

  // Phase register; wraps to 0 after the last phase.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase_q <= '0;
    end else if (adv) begin
      phase_q <= last ? '0 : phase_q + PW'(1);
    end
  end

  // One-hot decode of the current phase.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NPHASE; i++) begin
      onehot[i] = (phase_q == PW'(i));
    end
  end

endmodule

// File: rtl/clock_controller.sv
// Run/halt/single-step sequencer producing per-instruction phase enables.
module clock_controller
  import clock_controller_pkg::*;
#(
  parameter int unsigned NPHASE = 4,
  parameter int unsigned AW     = DATAWIDTH,
  parameter int unsigned CNTW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [AW-1:0]     pc,
  input  logic              bp_en,
  input  logic [AW-1:0]     bp_addr,
  input  logic              clr_count,
  output logic [NPHASE-1:0] phase_en,
  output logic              insn_done,
  output logic              running,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [CNTW-1:0]   instr_count
);

  state_e        state_q, state_d;
  halt_cause_e   cause_q, cause_d;
  logic          pend_q, pend_d;
  logic [NPHASE-1:0] phase_onehot;
  logic          phase_last;
  logic          bp_hit;

  clock_phase_gen #(.NPHASE(NPHASE)) u_phase (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == HALTED),
    .adv    (state_q != HALTED),
    .onehot (phase_onehot),
    .last   (phase_last)
  );

  // Breakpoint compares the next pc, so the stop precedes that instruction.
  assign bp_hit = bp_en && (pc == bp_addr);

  // Outputs decoded purely from registered state.
  assign running    = (state_q != HALTED);
  assign halted     = (state_q == HALTED);
  assign phase_en   = running ? phase_onehot : '0;
  assign insn_done  = running && phase_last;
  assign halt_cause = 2'(cause_q);

  // State, pending-halt and cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HALTED;
      cause_q <= HC_RESET;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic; stops only at instruction boundaries.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pend_d  = pend_q;
    unique case (state_q)
      HALTED: begin
        if (run_req) begin
          state_d = RUN;
        end else if (step_req) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (halt_req) begin
          pend_d = 1'b1;
        end
        if (phase_last) begin
          if (bp_hit) begin
            state_d = HALTED;
            cause_d = HC_BREAK;
          end else if (pend_q || halt_req) begin
            state_d = HALTED;
            cause_d = HC_USER;
          end
        end
      end
      STEP: begin
        if (phase_last) begin
          state_d = HALTED;
          cause_d = bp_hit ? HC_BREAK : HC_STEP;
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
    if (state_d == HALTED) begin
      pend_d = 1'b0;
    end
  end

  // Retired-instruction counter; clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      instr_count <= '0;
    end else if (insn_done) begin
      instr_count <= instr_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_clock_controller.sv
// Bench for clock_controller: vector table, corner sequences, random vs. model.
module tb_clock_controller;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, run_req, halt_req, step_req, bp_en, clr_count;
  logic [AW-1:0] pc, bp_addr;
  logic [NP-1:0] phase_en;
  logic          insn_done, running, halted;
  logic [1:0]    halt_cause;
  logic [CW-1:0] instr_count;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: busy executing an instruction or not, and which phase.
  bit m_busy, m_step, m_pend;
  int m_ph, m_cause, m_cnt;
  bit done_seen;

  clock_controller #(.NPHASE(NP), .AW(AW), .CNTW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .pc          (pc),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .clr_count   (clr_count),
    .phase_en    (phase_en),
    .insn_done   (insn_done),
    .running     (running),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [14:0] dut_out();
    return {phase_en, insn_done, running, halted, halt_cause, instr_count};
  endfunction

  function automatic logic [14:0] exp_out();
    logic [3:0] pe;
    pe = m_busy ? 4'(1 << m_ph) : 4'b0000;
    return {pe, (m_busy && m_ph == NP - 1), m_busy, !m_busy, 2'(m_cause), 4'(m_cnt)};
  endfunction

  // One clock of the model, written from the sequencing rules.
  task automatic model_step(input bit r, rn, h, s, be, input logic [AW-1:0] p, input bit c);
    bit last;
    if (r) begin
      m_busy = 0; m_step = 0; m_pend = 0; m_ph = 0; m_cause = 0; m_cnt = 0;
      return;
    end
    last = m_busy && (m_ph == NP - 1);
    if (c) m_cnt = 0;
    else if (last) m_cnt = (m_cnt + 1) % (1 << CW);
    if (!m_busy) begin
      if (rn || s) begin
        m_busy = 1; m_step = !rn; m_ph = 0;
      end
    end else begin
      if (!m_step && h) m_pend = 1;
      if (last) begin
        m_ph = 0;
        if (be && p == bp_addr) begin m_busy = 0; m_cause = 2; end
        else if (m_step)       begin m_busy = 0; m_cause = 3; end
        else if (m_pend)       begin m_busy = 0; m_cause = 1; end
        if (!m_busy) m_pend = 0;
      end else begin
        m_ph++;
      end
    end
  endtask

  task automatic tick(input bit r, rn, h, s, be, input logic [AW-1:0] p, input bit c);
    @(negedge clk);
    rst = r; run_req = rn; halt_req = h; step_req = s; bp_en = be; pc = p; clr_count = c;
    @(posedge clk);
    model_step(r, rn, h, s, be, p, c);
    #1;
    if (insn_done) done_seen = 1;
    chk("model", 32'(dut_out()), 32'(exp_out()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 16'h0, 0);
  endtask

  // Run until the model sits in the last phase of an instruction.
  task automatic to_last_phase();
    for (int i = 0; i < 8 && !(m_busy && m_ph == NP - 1); i++) idle(1);
  endtask

  typedef struct {
    bit run, halt, step, be, clr;
    logic [15:0] pc;
    logic [3:0]  pe;
    bit          done, hlt;
    logic [1:0]  cause;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs = '{
      '{0,0,1,0,0,16'h0000,4'b0001,0,0,2'd0,4'd0},
      '{0,0,0,0,0,16'h0000,4'b0010,0,0,2'd0,4'd0},
      '{0,0,0,0,0,16'h0000,4'b0100,0,0,2'd0,4'd0},
      '{0,0,0,0,0,16'h0000,4'b1000,1,0,2'd0,4'd0},
      '{0,0,0,0,0,16'h0000,4'b0000,0,1,2'd3,4'd1},
      '{1,0,0,0,0,16'h0000,4'b0001,0,0,2'd3,4'd1},
      '{0,0,0,0,0,16'h0000,4'b0010,0,0,2'd3,4'd1},
      '{0,0,0,0,0,16'h0000,4'b0100,0,0,2'd3,4'd1},
      '{0,0,0,1,0,16'h0000,4'b1000,1,0,2'd3,4'd1},
      '{0,0,0,1,0,16'h0010,4'b0000,0,1,2'd2,4'd2},
      '{1,0,0,1,0,16'h0000,4'b0001,0,0,2'd2,4'd2},
      '{0,0,0,1,0,16'h0000,4'b0010,0,0,2'd2,4'd2},
      '{0,0,0,1,0,16'h0000,4'b0100,0,0,2'd2,4'd2},
      '{0,0,0,1,0,16'h0000,4'b1000,1,0,2'd2,4'd2},
      '{0,0,0,1,0,16'h0011,4'b0001,0,0,2'd2,4'd3},
      '{0,1,0,1,0,16'h0000,4'b0010,0,0,2'd2,4'd3},
      '{0,0,0,1,0,16'h0000,4'b0100,0,0,2'd2,4'd3},
      '{0,0,0,1,0,16'h0000,4'b1000,1,0,2'd2,4'd3},
      '{0,0,0,1,0,16'h0000,4'b0000,0,1,2'd1,4'd4},
      '{0,0,0,0,1,16'h0000,4'b0000,0,1,2'd1,4'd0}
    };
    rst = 0; run_req = 0; halt_req = 0; step_req = 0; bp_en = 0; clr_count = 0;
    pc = '0; bp_addr = 16'h0010;
    m_busy = 0; m_step = 0; m_pend = 0; m_ph = 0; m_cause = 0; m_cnt = 0;
    done_seen = 0;

    // Reset state.
    tick(1, 0, 0, 0, 0, 16'h0, 0);
    tick(1, 0, 0, 0, 0, 16'h0, 0);
    chk("reset_state", 32'(dut_out()), 32'({4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0}));

    // Step, breakpoint, resume past breakpoint, user halt, clear.
    foreach (vecs[i]) begin
      tick(0, vecs[i].run, vecs[i].halt, vecs[i].step, vecs[i].be, vecs[i].pc, vecs[i].clr);
      chk($sformatf("vec%0d", i), 32'(dut_out()),
          32'({vecs[i].pe, vecs[i].done, !vecs[i].hlt, vecs[i].hlt, vecs[i].cause, vecs[i].cnt}));
    end

    // User halt during phase 1 of instruction 3 finishes that instruction only.
    tick(1, 0, 0, 0, 0, 16'h0, 0);
    tick(0, 1, 0, 0, 0, 16'h0, 0);
    idle(9);
    tick(0, 0, 1, 0, 0, 16'h0, 0);
    idle(2);
    chk("user_halt", 32'({halted, halt_cause, instr_count}), 32'({1'b1, 2'd1, 4'd3}));
    idle(2);
    chk("user_halt_stays", 32'({halted, phase_en, instr_count}), 32'({1'b1, 4'b0000, 4'd3}));

    // Reset in RUN at phase 2 aborts without insn_done or count.
    tick(0, 1, 0, 0, 0, 16'h0, 0);
    idle(2);
    chk("reset_mid_phase", 32'(phase_en), 32'(4'b0100));
    done_seen = 0;
    tick(1, 0, 0, 0, 0, 16'h0, 0);
    tick(1, 0, 0, 0, 0, 16'h0, 0);
    idle(1);
    chk("reset_mid_out", 32'(dut_out()), 32'({4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0}));
    chk("reset_no_done", 32'(done_seen), 32'(0));

    // run_req with step_req runs continuously.
    tick(0, 1, 0, 1, 0, 16'h0, 0);
    idle(6);
    chk("run_wins", 32'({running, instr_count}), 32'({1'b1, 4'd1}));

    // halt_req exactly on the last phase stops at that boundary.
    to_last_phase();
    tick(0, 0, 1, 0, 0, 16'h0, 0);
    chk("halt_on_last", 32'({halted, halt_cause, instr_count}), 32'({1'b1, 2'd1, 4'd2}));

    // Clear coincident with insn_done wins.
    tick(0, 1, 0, 0, 0, 16'h0, 0);
    to_last_phase();
    tick(0, 0, 0, 0, 0, 16'h0, 1);
    chk("clr_vs_inc", 32'(instr_count), 32'(0));
    to_last_phase();
    tick(0, 0, 1, 0, 0, 16'h0, 0);

    // Counter wrap after 2^CW-1 instructions.
    tick(0, 0, 0, 0, 0, 16'h0, 1);
    tick(0, 1, 0, 0, 0, 16'h0, 0);
    idle(NP * 15);
    chk("cnt_full", 32'(instr_count), 32'(4'hf));
    idle(NP);
    chk("cnt_wrap", 32'(instr_count), 32'(0));
    to_last_phase();
    tick(0, 0, 1, 0, 0, 16'h0, 0);

    // Breakpoint self-loop re-halts after every resumed iteration.
    for (int k = 0; k < 2; k++) begin
      tick(0, 1, 0, 0, 1, 16'h0, 0);
      idle(2);
      tick(0, 0, 0, 0, 1, 16'h0, 0);
      tick(0, 0, 0, 0, 1, 16'h0010, 0);
      chk("bp_loop", 32'({halted, halt_cause}), 32'({1'b1, 2'd2}));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] p;
      case ($urandom_range(0, 3))
        0, 1:    p = 16'h0010;
        2:       p = 16'h0011;
        default: p = 16'($urandom);
      endcase
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
           1'($urandom), p, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clock_controller.md
Name: clock_controller

Overview:
- Run/halt/single-step sequencer for the system clock.
- Divides each SUBLEQ instruction into NPHASE one-hot phase enables, which the CPU and memory cards use as qualified clock enables.
- Halts only at instruction boundaries, on a front-panel request, an address breakpoint or single-step completion.
- Counts retired instructions for the debug card.

Parameters:
NPHASE, 4, phases per instruction (>= 2).
AW, `DATAWIDTH, width of pc and bp_addr.
CNTW, 32, width of retired-instruction counter.

Ports:
clk  input  1  system clock from the clock card.
rst  input  1  synchronous, active-high reset.
run_req  input  1  pulse: start continuous execution.
halt_req  input  1  pulse: stop at end of current instruction.
step_req  input  1  pulse: execute exactly one instruction.
pc  input  AW  address of next instruction; valid during the last phase.
bp_en  input  1  breakpoint enable.
bp_addr  input  AW  breakpoint address.
clr_count  input  1  synchronous clear of instr_count.
phase_en  output  NPHASE  one-hot phase enable; all-zero when halted.
insn_done  output  1  high during the last phase of every instruction.
running  output  1  high in RUN, STEP or DRAIN.
halted  output  1  high in HALTED.
halt_cause  output  2  0 = reset, 1 = user halt, 2 = breakpoint, 3 = step complete.
instr_count  output  CNTW  retired instructions, wraps modulo 2^CNTW.

Behaviour:
- Reset (rst sampled high on clk edge):
  - state = HALTED, phase = 0, halt_pend = 0.
  - phase_en = 0, insn_done = 0, running = 0, halted = 1, halt_cause = 0, instr_count = 0.
  - Reset mid-instruction aborts it immediately; no insn_done and no count increment for the aborted instruction.
- Timing: all outputs are decoded from registers only; no combinational input-to-output path.
- States:
  - HALTED: run_req -> RUN; else step_req -> STEP. run_req wins if both arrive together. halt_req is ignored. Phase is forced to 0.
  - RUN: phase advances 0..NPHASE-1 every cycle and wraps to 0. A halt_req in any cycle sets halt_pend. At the last phase:
    - if bp_en && pc == bp_addr -> HALTED, cause 2;
    - else if halt_pend, or halt_req in that same cycle -> HALTED, cause 1;
    - else stay in RUN at phase 0.
  - STEP: one full instruction, then HALTED with cause 3. If a breakpoint matches at the last phase, cause 2 instead. halt_req is ignored; run_req is ignored.
  - DRAIN: not used as a separate encoded state; halt_pend in RUN provides drain semantics. running stays high until the boundary.
- Latency:
  - Request pulse at edge N -> running = 1 and phase_en = 0...01 after edge N+1.
  - Last phase at edge N+NPHASE -> halted = 1 after edge N+NPHASE+1.
- insn_done equals phase_en[NPHASE-1] whenever running.
- instr_count:
  - Increments on every insn_done cycle.
  - clr_count has priority over a simultaneous increment (result is 0).
  - Wraps from all-ones to 0.
- Breakpoints:
  - Checked only at instruction end, against the next pc, so the stop happens before the instruction at bp_addr executes.
  - Resuming executes that instruction. A self-loop at bp_addr re-halts after each iteration.
- Pending halt: halt_pend clears on entering HALTED. halt_cause holds its value until the next halt or reset.

Decomposition:
- Shared package:
  - state encoding: HALTED, RUN, STEP;
  - halt_cause codes: HC_RESET, HC_USER, HC_BREAK, HC_STEP.
- Sub-module clock_phase_gen: phase counter with clear and advance enable, one-hot decode, last-phase flag.
- Everything else (FSM, pending flag, breakpoint compare, counter) lives in clock_controller.

Test Plan:
- Reset: rst high 2 cycles during RUN phase 2 -> next cycle halted = 1, phase_en = 0000, instr_count = 0, halt_cause = 0, insn_done never seen.
- Single step (NPHASE = 4): step_req pulse -> phase_en 0001, 0010, 0100, 1000 on 4 consecutive cycles; insn_done with 1000; then halted = 1, instr_count = 1, halt_cause = 3.
- User halt: run_req, then halt_req during phase 0010 of instruction 3 -> phases finish through 1000; halted; instr_count = 3; halt_cause = 1; no partial 4th instruction.
- Breakpoint: bp_en = 1, bp_addr = 0x0010, pc = 0x0010 at end of instruction 2 -> halted, count = 2, cause = 2. run_req -> executes again; with pc = 0x0011 at its end it continues running.
- Simultaneous requests:
  - run_req + step_req in HALTED -> RUN (continuous, no halt after 1 instruction).
  - halt_req exactly on the last phase -> halts at that boundary.
- Counter: clr_count coincident with insn_done -> instr_count = 0. Preload near wrap by running 2^CNTW-1 instructions (CNTW = 4 in bench) -> next increment gives 0.
